noise_src: RTL and testbench

NOISE_SRC -- requirements
Module: noise_src

---
 rtl/noise_src.sv | 123 ++++++++++++
 tb/tb_noise_src.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/noise_src.sv
// LFSR noise source: uniform samples or an approximate Gaussian (CLT sum), arithmetic-shift attenuated.
// One registered sample per enabled cycle (Gaussian: one per 2^SUM_LOG2); noise_en gates progress, no backpressure.
module noise_src #(
    parameter int          OUT_W    = 16,
    parameter int          SUM_LOG2 = 2,
    parameter logic [31:0] SEED     = 32'hACE1_2468
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    noise_en,
    input  logic                    mode,
    input  logic                    seed_load,
    input  logic [31:0]             seed_in,
    input  logic [3:0]              amp,
    output logic signed [OUT_W-1:0] noise_out,
    output logic                    noise_valid
);

    localparam int SUM_W = OUT_W + SUM_LOG2;
    localparam int CNT_W = (SUM_LOG2 > 0) ? SUM_LOG2 : 1;
    localparam int SHIFT = (SUM_LOG2 + 1) / 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << SUM_LOG2) - 1);
    localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_LOG2 + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_LOG2 + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        UNI,
        ACC
    } state_t;

    state_t                  state_q, state_d;
    logic [31:0]             lfsr_q, lfsr_d;
    logic signed [SUM_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [OUT_W-1:0] out_q, out_d;
    logic                    vld_q, vld_d;

    logic                    fb;
    logic signed [OUT_W-1:0] sample;
    logic signed [SUM_W-1:0] sample_ext;
    logic signed [SUM_W-1:0] base_sum;
    logic [CNT_W-1:0]        base_cnt;
    logic signed [SUM_W-1:0] acc_sum;
    logic signed [SUM_W-1:0] acc_shr;
    logic signed [OUT_W-1:0] sat_val;

    assign fb         = lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0];
    assign sample     = lfsr_q[31 -: OUT_W];
    assign sample_ext = SUM_W'(sample);

    // Entering ACC from any other state starts a fresh sum with this cycle's sample.
    assign base_sum = (state_q == ACC) ? sum_q : '0;
    assign base_cnt = (state_q == ACC) ? cnt_q : '0;
    assign acc_sum  = base_sum + sample_ext;
    assign acc_shr  = acc_sum >>> SHIFT;

    always_comb begin
        sat_val = acc_shr[OUT_W-1:0];
        if (acc_shr > SAT_MAX) begin
            sat_val = SAT_MAX[OUT_W-1:0];
        end else if (acc_shr < SAT_MIN) begin
            sat_val = SAT_MIN[OUT_W-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        vld_d   = 1'b0;
        if (seed_load) begin
            lfsr_d  = (seed_in == 32'd0) ? SEED : seed_in;
            sum_d   = '0;
            cnt_d   = '0;
            state_d = IDLE;
        end else if (noise_en) begin
            lfsr_d = {lfsr_q[30:0], fb};
            if (!mode) begin
                state_d = UNI;
                out_d   = sample >>> amp;
                vld_d   = 1'b1;
                sum_d   = '0;
                cnt_d   = '0;
            end else begin
                state_d = ACC;
                if (base_cnt == CNT_LAST) begin
                    out_d = sat_val >>> amp;
                    vld_d = 1'b1;
                    sum_d = '0;
                    cnt_d = '0;
                end else begin
                    sum_d = acc_sum;
                    cnt_d = base_cnt + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lfsr_q  <= SEED;
            sum_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
        end
    end

    assign noise_out   = out_q;
    assign noise_valid = vld_q;

endmodule

// File: tb/tb_noise_src.sv
// Bench for noise_src: hand-computed vector table, multi-cycle corner sequences, then a randomized model comparison.
module tb_noise_src;

    localparam logic [31:0] SEED = 32'hACE1_2468;

    logic        clk = 1'b0;
    logic        rst, noise_en, mode, seed_load;
    logic [31:0] seed_in;
    logic [3:0]  amp;
    logic [15:0] noise_out;
    logic        noise_valid;

    always #5 clk = ~clk;

    noise_src #(.OUT_W(16), .SUM_LOG2(2), .SEED(SEED)) dut (
        .clk        (clk),
        .rst        (rst),
        .noise_en   (noise_en),
        .mode       (mode),
        .seed_load  (seed_load),
        .seed_in    (seed_in),
        .amp        (amp),
        .noise_out  (noise_out),
        .noise_valid(noise_valid)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model, written from the behavioural description with plain integers.
    logic [31:0] m_lfsr;
    int          m_state;   // 0 idle, 1 uniform, 2 accumulating
    int          m_sum, m_cnt;
    logic [15:0] m_out;
    logic        m_vld;

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
    endfunction

    task automatic model_step(input logic r, input logic e, input logic m, input logic l,
                              input logic [31:0] sd, input logic [3:0] a);
        int s, v;
        m_vld = 1'b0;
        if (r) begin
            m_lfsr = SEED; m_sum = 0; m_cnt = 0; m_state = 0; m_out = 16'h0;
        end else if (l) begin
            m_lfsr = (sd == 0) ? SEED : sd; m_sum = 0; m_cnt = 0; m_state = 0;
        end else if (e) begin
            s = int'($signed(m_lfsr[31:16]));
            m_lfsr = lfsr_step(m_lfsr);
            if (!m) begin
                m_state = 1; m_sum = 0; m_cnt = 0;
                m_out = 16'(s >>> a);
                m_vld = 1'b1;
            end else begin
                if (m_state != 2) begin
                    m_sum = 0; m_cnt = 0;
                end
                m_state = 2;
                m_sum += s;
                m_cnt++;
                if (m_cnt == 4) begin
                    v = m_sum >>> 1;
                    if (v > 32767) v = 32767;
                    if (v < -32768) v = -32768;
                    m_out = 16'(v >>> a);
                    m_vld = 1'b1;
                    m_sum = 0; m_cnt = 0;
                end
            end
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic m, input logic l,
                         input logic [31:0] sd, input logic [3:0] a);
        rst = r; noise_en = e; mode = m; seed_load = l; seed_in = sd; amp = a;
        model_step(r, e, m, l, sd, a);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_model(input string name);
        chk({name, ".out"}, {16'h0, noise_out}, {16'h0, m_out});
        chk({name, ".vld"}, {31'h0, noise_valid}, {31'h0, m_vld});
    endtask

    typedef struct {
        logic        rst, en, mode, sl;
        logic [31:0] seed;
        logic [3:0]  amp;
        logic [15:0] exp_out;
        logic        exp_vld;
        logic        chk_lfsr;
        logic [31:0] exp_lfsr;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic e, input logic m, input logic l,
                                input logic [31:0] sd, input logic [3:0] a,
                                input logic [15:0] eo, input logic ev,
                                input logic cl, input logic [31:0] el);
        vec_t v;
        v.rst = r; v.en = e; v.mode = m; v.sl = l; v.seed = sd; v.amp = a;
        v.exp_out = eo; v.exp_vld = ev; v.chk_lfsr = cl; v.exp_lfsr = el;
        return v;
    endfunction

    vec_t vecs[19];

    initial begin
        rst = 1'b1; noise_en = 1'b0; mode = 1'b0; seed_load = 1'b0; seed_in = '0; amp = '0;
        m_lfsr = SEED; m_state = 0; m_sum = 0; m_cnt = 0; m_out = '0; m_vld = 1'b0;

        //             rst en md sl seed           amp out       vld chkL lfsr
        vecs[0]  = mk(1, 1, 0, 0, 32'h0,         0,  16'h0000, 0, 1, SEED);
        vecs[1]  = mk(1, 1, 0, 0, 32'h0,         0,  16'h0000, 0, 1, SEED);
        vecs[2]  = mk(1, 1, 0, 0, 32'h0,         0,  16'h0000, 0, 1, SEED);
        vecs[3]  = mk(0, 1, 0, 1, 32'hFFFF_FFFF, 0,  16'h0000, 0, 1, 32'hFFFF_FFFF);
        vecs[4]  = mk(0, 1, 0, 0, 32'h0,         0,  16'hFFFF, 1, 1, 32'hFFFF_FFFE);
        vecs[5]  = mk(0, 1, 0, 0, 32'h0,         0,  16'hFFFF, 1, 1, 32'hFFFF_FFFD);
        vecs[6]  = mk(0, 0, 0, 0, 32'h0,         0,  16'hFFFF, 0, 1, 32'hFFFF_FFFD);
        vecs[7]  = mk(0, 1, 0, 1, 32'h8000_0001, 0,  16'hFFFF, 0, 1, 32'h8000_0001);
        vecs[8]  = mk(0, 1, 0, 0, 32'h0,         3,  16'hF000, 1, 0, 32'h0);
        vecs[9]  = mk(0, 0, 1, 1, 32'hFFFF_FFFF, 0,  16'hF000, 0, 0, 32'h0);
        vecs[10] = mk(0, 1, 1, 0, 32'h0,         0,  16'hF000, 0, 0, 32'h0);
        vecs[11] = mk(0, 1, 1, 0, 32'h0,         0,  16'hF000, 0, 0, 32'h0);
        vecs[12] = mk(0, 1, 1, 0, 32'h0,         0,  16'hF000, 0, 0, 32'h0);
        vecs[13] = mk(0, 1, 1, 0, 32'h0,         0,  16'hFFFE, 1, 0, 32'h0);
        vecs[14] = mk(1, 0, 0, 0, 32'h0,         0,  16'h0000, 0, 1, SEED);
        vecs[15] = mk(0, 1, 0, 0, 32'h0,         0,  16'hACE1, 1, 1, 32'h59C2_48D0);
        vecs[16] = mk(0, 1, 0, 0, 32'h0,         4,  16'h059C, 1, 0, 32'h0);
        vecs[17] = mk(0, 0, 0, 0, 32'h0,         4,  16'h059C, 0, 0, 32'h0);
        vecs[18] = mk(0, 1, 0, 0, 32'h0,         15, 16'hFFFF, 1, 0, 32'h0);

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].sl, vecs[i].seed, vecs[i].amp);
            chk($sformatf("vec%0d.out", i), {16'h0, noise_out}, {16'h0, vecs[i].exp_out});
            chk($sformatf("vec%0d.vld", i), {31'h0, noise_valid}, {31'h0, vecs[i].exp_vld});
            if (vecs[i].chk_lfsr)
                chk($sformatf("vec%0d.lfsr", i), dut.lfsr_q, vecs[i].exp_lfsr);
        end

        // Zero seed falls back to SEED; mode flip mid-sum drops the partial sum.
        drive(0, 1, 0, 1, 32'h0, 0);
        chk("zero_seed.lfsr", dut.lfsr_q, SEED);
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 1, 0, 32'h0, 0);
            chk($sformatf("flip_pre%0d.vld", i), {31'h0, noise_valid}, 32'h0);
        end
        drive(0, 1, 0, 0, 32'h0, 0);
        chk_model("flip_uni");
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 0, 32'h0, 0);
            chk($sformatf("flip_post%0d.vld", i), {31'h0, noise_valid}, 32'h0);
        end
        drive(0, 1, 1, 0, 32'h0, 0);
        chk("flip_gauss.vld", {31'h0, noise_valid}, 32'h1);
        chk_model("flip_gauss");

        // Reset in the middle of an accumulation.
        drive(0, 1, 1, 1, 32'hFFFF_FFFF, 0);
        drive(0, 1, 1, 0, 32'h0, 0);
        drive(0, 1, 1, 0, 32'h0, 0);
        drive(1, 1, 1, 1, 32'h1234_5678, 0);
        chk("midrst.out", {16'h0, noise_out}, 32'h0);
        chk("midrst.lfsr", dut.lfsr_q, SEED);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 0, 32'h0, 0);
            chk($sformatf("midrst_acc%0d.vld", i), {31'h0, noise_valid}, 32'h0);
        end
        drive(0, 1, 1, 0, 32'h0, 2);
        chk("midrst_gauss.vld", {31'h0, noise_valid}, 32'h1);
        chk_model("midrst_gauss");

        // Randomized run against the model.
        begin
            logic r, e, m, l;
            logic [31:0] sd;
            logic [3:0]  a;
            m = 1'b0;
            a = 4'd0;
            drive(1, 0, 0, 0, 32'h0, 0);
            for (int c = 0; c < 6000; c++) begin
                r  = ($urandom_range(0, 499) == 0);
                l  = ($urandom_range(0, 99) == 0);
                e  = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 19) == 0) m = ~m;
                if ($urandom_range(0, 9) == 0) a = 4'($urandom_range(0, 15));
                sd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
                drive(r, e, m, l, sd, a);
                chk_model($sformatf("rand%0d", c));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
